// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Pipeline stage register with a valid/ready handshake and a two-entry skid
// buffer. A downstream stall back-pressures upstream without dropping or
// duplicating payload. in_ready comes from a flop, so ready paths never chain
// combinationally from one stage to the next. Also provides a synchronous flush
// and a saturating stall counter.
//
// Parameters:
//   DATA_W     payload width in bits
//   CNT_W      stall counter width in bits
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous kill of all held entries
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  out_data is valid
//   out_ready  downstream accepts
//   out_data   head payload
//   occupancy  entries held (0, 1 or 2)
//   stall_clr  clears stall_cnt
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 15,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The state encoding equals the number of held entries.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [DATA_W-1:0]  r_main;
  logic [DATA_W-1:0]  w_main_d;
  logic [DATA_W-1:0]  r_skid;
  logic [DATA_W-1:0]  w_skid_d;
  logic               r_in_ready;
  logic               w_in_ready_d;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_out_valid;
  logic               w_in_acc;
  logic               w_out_acc;
  logic               w_stalled;
  logic               w_cnt_sat;

  // Handshake strobes. Both come only from flops and from the partner's strobe,
  // so no output depends combinationally on an input.
  assign w_out_valid = (r_state != StEmpty);
  assign w_in_acc    = in_valid & r_in_ready;
  assign w_out_acc   = w_out_valid & out_ready;
  assign w_stalled   = w_out_valid & ~out_ready;
  assign w_cnt_sat   = (r_stall_cnt == {CNT_W{1'b1}});

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StEmpty;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_in_ready <= w_in_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    if (flush) begin
      // Anything handshaken this cycle is dropped. A head consumed by the
      // downstream in the same cycle has already left.
      w_state_d = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_in_acc) w_state_d = StOne;
        end
        StOne: begin
          if (w_in_acc && !w_out_acc)      w_state_d = StFull;
          else if (!w_in_acc && w_out_acc) w_state_d = StEmpty;
          else                             w_state_d = StOne;
        end
        StFull: begin
          // in_ready is low in FULL, so only a dequeue can happen here.
          if (w_out_acc) w_state_d = StOne;
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  // Registered ready: high whenever the stage will have a free slot next cycle.
  assign w_in_ready_d = (w_state_d != StFull);

  // ---------------------------------------------------------------------------
  // Payload next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_main_d = r_main;
    w_skid_d = r_skid;
    if (flush) begin
      w_main_d = '0;
      w_skid_d = '0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_in_acc) w_main_d = in_data;
        end
        StOne: begin
          // With a simultaneous dequeue the new word becomes the head.
          // Otherwise it parks in the skid behind the current head.
          if (w_in_acc && w_out_acc) w_main_d = in_data;
          else if (w_in_acc)         w_skid_d = in_data;
        end
        StFull: begin
          if (w_out_acc) w_main_d = r_skid;
        end
        default: begin
          w_main_d = r_main;
          w_skid_d = r_skid;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      r_main <= w_main_d;
      r_skid <= w_skid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter: saturates, clear beats increment, flush does not touch it
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stalled && !w_cnt_sat) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = w_out_valid;
    out_data  = r_main;
    occupancy = r_state;
    in_ready  = r_in_ready;
    stall_cnt = r_stall_cnt;
  end

`ifndef SYNTHESIS
  // The registered ready must always track the current fill level.
  a_ready_tracks_state : assert property (@(posedge clk) disable iff (rst)
    r_in_ready == (r_state != StFull));

  // The unused encoding must never be reached.
  a_state_legal : assert property (@(posedge clk) disable iff (rst)
    r_state != 2'd3);

  // The guard on in_ready means FULL can never take an input.
  a_no_accept_full : assert property (@(posedge clk) disable iff (rst)
    !(r_state == StFull && w_in_acc));
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int unsigned DW = 15;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic          stall_clr = 1'b0;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          clr;
    logic          eir;
    logic          eov;
    logic [DW-1:0] eod;
    logic [1:0]    eocc;
    logic [CW-1:0] est;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock once, leave time just past the edge.
  task automatic step(input logic r, input logic f, input logic iv, input logic [DW-1:0] d,
                      input logic ordy, input logic clr);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy; stall_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic eir, input logic eov,
                         input logic [DW-1:0] eod, input logic [1:0] eocc,
                         input logic [CW-1:0] est);
    chk({tag, ".in_ready"}, int'(in_ready), int'(eir));
    chk({tag, ".out_valid"}, int'(out_valid), int'(eov));
    chk({tag, ".out_data"}, int'(out_data), int'(eod));
    chk({tag, ".occupancy"}, int'(occupancy), int'(eocc));
    chk({tag, ".stall_cnt"}, int'(stall_cnt), int'(est));
  endtask

  initial begin
    int unsigned exp_st;
    logic [DW-1:0] q[$];
    logic [DW-1:0] seq;
    logic          cur_iv;
    logic          cur_or;

    //               rst  fl   iv   data    ordy clr  eir  eov  eod     eocc  est
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 15'h000, 1'b0, 1'b0, 1'b1, 1'b0, 15'h000, 2'd0, 4'd0};
    // Streaming, one transfer per cycle.
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 15'h001, 1'b1, 1'b0, 1'b1, 1'b1, 15'h001, 2'd1, 4'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 15'h002, 1'b1, 1'b0, 1'b1, 1'b1, 15'h002, 2'd1, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 15'h003, 1'b1, 1'b0, 1'b1, 1'b1, 15'h003, 2'd1, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 15'h000, 1'b1, 1'b0, 1'b1, 1'b0, 15'h003, 2'd0, 4'd0};
    // Back-pressure: A3 held upstream while full.
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 15'h0A1, 1'b0, 1'b0, 1'b1, 1'b1, 15'h0A1, 2'd1, 4'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 15'h0A2, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0A1, 2'd2, 4'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 15'h0A3, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0A1, 2'd2, 4'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 15'h0A3, 1'b1, 1'b0, 1'b1, 1'b1, 15'h0A2, 2'd1, 4'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 15'h0A3, 1'b1, 1'b0, 1'b1, 1'b1, 15'h0A3, 2'd1, 4'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 15'h000, 1'b1, 1'b0, 1'b1, 1'b0, 15'h0A3, 2'd0, 4'd2};
    // Fill, then flush from FULL with 7FF on the input.
    vecs[11] = '{1'b0, 1'b0, 1'b1, 15'h011, 1'b0, 1'b0, 1'b1, 1'b1, 15'h011, 2'd1, 4'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 15'h022, 1'b0, 1'b0, 1'b0, 1'b1, 15'h011, 2'd2, 4'd3};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 15'h7FF, 1'b0, 1'b0, 1'b1, 1'b0, 15'h000, 2'd0, 4'd4};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 15'h000, 1'b0, 1'b0, 1'b1, 1'b0, 15'h000, 2'd0, 4'd4};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 15'h055, 1'b0, 1'b0, 1'b1, 1'b1, 15'h055, 2'd1, 4'd4};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].eir, vecs[i].eov, vecs[i].eod, vecs[i].eocc,
              vecs[i].est);
    end

    // Stall counter saturation: 20 stalled cycles starting from 4.
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      exp_st = (4 + k > 15) ? 15 : 4 + k;
      chk($sformatf("sat%0d.stall_cnt", k), int'(stall_cnt), int'(exp_st));
    end
    chk("sat.out_data", int'(out_data), 'h055);

    // Clear beats the increment of a stalled cycle.
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("clr.stall_cnt", int'(stall_cnt), 0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("clr_inc.stall_cnt", int'(stall_cnt), 1);

    // Flush together with a dequeue: count untouched.
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk_all("flush_deq", 1'b1, 1'b0, 15'h000, 2'd0, 4'd1);

    // Fill to FULL, then reset together with flush and stall_clr.
    step(1'b0, 1'b0, 1'b1, 15'h0B1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 15'h0B2, 1'b0, 1'b0);
    chk_all("refill", 1'b0, 1'b1, 15'h0B1, 2'd2, 4'd2);
    step(1'b1, 1'b1, 1'b1, 15'h0C3, 1'b0, 1'b1);
    chk_all("rst_full", 1'b1, 1'b0, 15'h000, 2'd0, 4'd0);

    // Random traffic against a queue scoreboard.
    seq = 15'h100;
    rst = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      cur_iv = ($urandom_range(0, 3) != 0);
      cur_or = ($urandom_range(0, 2) != 0);
      in_valid = cur_iv;
      in_data = seq;
      out_ready = cur_or;
      #1;
      chk("rnd.in_ready", int'(in_ready), int'(occupancy != 2'd2));
      chk("rnd.occupancy", int'(occupancy), q.size());
      chk("rnd.out_valid", int'(out_valid), int'(q.size() != 0));
      if (out_valid && cur_or && q.size() != 0) begin
        chk("rnd.out_data", int'(out_data), int'(q[0]));
        void'(q.pop_front());
      end
      if (cur_iv && in_ready) begin
        q.push_back(seq);
        seq = seq + 1'b1;
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a saturating stall counter. It sits between any two pipeline stages, such as EX/MEM or MEM/WB. It replaces the fixed-width, always-advancing stage registers so that a downstream stall back-pressures upstream without dropping or duplicating payload. Its `in_ready` is driven from a flop, so ready paths do not chain combinationally across stages.

## Interface
Parameters:
- `DATA_W`, 15: payload width in bits. The default carries rs1/rs2/rd addresses, 3 x 5 bits.
- `CNT_W`, 16: stall counter width in bits.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous kill of all held entries.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  head payload.
- `occupancy`  out  2  entries held: 0, 1 or 2.
- `stall_clr`  in  1  clears `stall_cnt`.
- `stall_cnt`  out  CNT_W  cycles with `out_valid & !out_ready`, saturating.

## Operation
- Storage and states:
  - Two registers: `main` drives `out_data`; `skid` is the overflow entry.
  - States are EMPTY (0 entries), ONE (1 entry) and FULL (2 entries). `occupancy` encodes the state.
- Handshake strobes: input accept = `in_valid & in_ready`; output accept = `out_valid & out_ready`.
- Output flags:
  - `out_valid` = (state != EMPTY).
  - `in_ready` is registered and equals 1 exactly when the next state is not FULL.
- Transitions when neither `rst` nor `flush` is active:
  - EMPTY, input accept: `main <= in_data`, go to ONE.
  - ONE, input accept and output accept: `main <= in_data`, stay in ONE.
  - ONE, input accept only: `skid <= in_data`, go to FULL.
  - ONE, output accept only: go to EMPTY.
  - FULL, output accept: `main <= skid`, go to ONE. No input accept is possible because `in_ready` = 0.
  - Any other case: hold state and data.
- Ordering: payload leaves in arrival order. No entry is ever duplicated or lost except by `flush`.
- Data clearing:
  - Entries freed by a dequeue keep their stale data.
  - `out_data` is only meaningful while `out_valid` = 1.
- `flush` takes priority over all handshakes and is below `rst`:
  - Next state is EMPTY; `main` and `skid` are cleared to 0; `in_ready` is set to 1.
  - A transfer presented during the flush cycle is discarded. Upstream still sees it as handshaken.
  - An output accept in the same cycle is legal; the downstream consumes the current head.
- `stall_cnt`:
  - Increments by 1 in every cycle where `out_valid & !out_ready`. It saturates at 2^CNT_W−1 and never wraps.
  - `stall_clr` forces it to 0 and wins over a simultaneous increment.
  - `flush` does not affect it; `rst` clears it.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `occupancy` = 0.
  - `in_ready` = 1, `stall_cnt` = 0.
  - The `skid` register resets to 0.
- Reset mid-operation: `rst` has the same effect whatever the state, and wins over `flush` and `stall_clr`.
- Latency: an input accept at edge N makes `out_valid` = 1 with that payload after edge N, visible in cycle N+1. There is no combinational path from input to output.
- Throughput: 1 transfer per cycle while `out_ready` is held high.
- Ready timing: `in_ready` falls in the cycle after the stage reaches FULL. It rises in the cycle after a FULL→ONE dequeue.
- Inputs and outputs: no output depends combinationally on any input.

## Test plan
- Reset, then stream 0x001, 0x002, 0x003 with `out_ready` = 1:
  - Outputs appear one cycle later, in order.
  - `occupancy` stays 1 and `stall_cnt` stays 0.
- Back-pressure: hold `out_ready` = 0 and offer 0x0A1, 0x0A2, 0x0A3:
  - 0x0A1 and 0x0A2 are accepted; `in_ready` = 0 from the next cycle and 0x0A3 is held upstream.
  - `occupancy` = 2.
  - After releasing `out_ready`, the output order is 0x0A1, 0x0A2, 0x0A3.
- Flush from FULL while `in_valid` = 1 carrying 0x7FF:
  - Next cycle shows `occupancy` = 0, `out_valid` = 0, `out_data` = 0 and `in_ready` = 1.
  - 0x7FF never appears at the output.
- Stall counter with CNT_W = 4 and `out_valid` held with `out_ready` = 0 for 20 cycles:
  - `stall_cnt` reaches 15 and holds there.
  - Asserting `stall_clr` in a stalled cycle gives 0 the next cycle.
  - `flush` leaves the count unchanged.
- Assert `rst` in FULL together with `flush` and `stall_clr`: all outputs take their reset values the next cycle.
- Random valid/ready traffic over 10k cycles with a scoreboard:
  - No loss, duplication or reordering.
  - `in_ready` always equals (`occupancy` != 2).
